// File: rtl/disp_mux.sv
// disp_mux: multiplexed driver for a 6-digit common-anode 7-segment display (HH.MM.SS).
//
// Scans one digit per SCAN_DIV clock cycles, in index order:
//   0 h_msd, 1 h_lsd, 2 m_msd, 3 m_lsd, 4 s_msd, 5 s_lsd.
// All digits are snapshotted together once per frame, on the 5->0 index wrap, so a
// carry rippling through the counters can never show as a torn time. The field
// selected by dsp_edit_sel blinks, with a half-period of BLINK_FRAMES frames.
//
// Ports:
//   dsp_clock    in   system clock; all state changes on its rising edge
//   dsp_reset    in   asynchronous, active-low reset
//   dsp_enable   in   1 = scan active; 0 = display dark and scan frozen
//   dsp_h_lsd    in   hours units (BCD, 4 bits)
//   dsp_h_msd    in   hours tens (2 bits)
//   dsp_m_lsd    in   minutes units (4 bits)
//   dsp_m_msd    in   minutes tens (3 bits)
//   dsp_s_lsd    in   seconds units (4 bits)
//   dsp_s_msd    in   seconds tens (3 bits)
//   dsp_edit_sel in   field to blink: 0 none, 1 hours, 2 minutes, 3 seconds
//   dsp_an       out  anode select, active-low one-hot; bit k drives digit index k
//   dsp_seg      out  segments {g,f,e,d,c,b,a}, active-low
//   dsp_dp       out  decimal point, active-low; lit after digits 1 and 3
module disp_mux #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 100
) (
  input  logic       dsp_clock,
  input  logic       dsp_reset,
  input  logic       dsp_enable,
  input  logic [3:0] dsp_h_lsd,
  input  logic [1:0] dsp_h_msd,
  input  logic [3:0] dsp_m_lsd,
  input  logic [2:0] dsp_m_msd,
  input  logic [3:0] dsp_s_lsd,
  input  logic [2:0] dsp_s_msd,
  input  logic [1:0] dsp_edit_sel,
  output logic [5:0] dsp_an,
  output logic [6:0] dsp_seg,
  output logic       dsp_dp
);

  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PrescW-1:0] PrescLast = PrescW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  localparam logic [2:0] LastDigit = 3'd5;

  // Active-low segment patterns.
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'h3F;

  // Scan and blink state.
  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        idx_q, idx_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              phase_q, phase_d;   // 1 = edited field visible
  logic [5:0][3:0]   snap_q, snap_d;     // element k holds digit index k
  logic [1:0]        sel_q, sel_d;       // shadow of dsp_edit_sel

  // Registered pin drivers.
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic       presc_wrap;
  logic       frame_wrap;
  logic       sel_change;
  logic [3:0] digit;
  logic [1:0] field;
  logic       blank;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  // Next-state logic for prescaler, index, snapshot and blink.
  always_comb begin
    presc_wrap = (presc_q == PrescLast);
    frame_wrap = presc_wrap && (idx_q == LastDigit);
    sel_change = (dsp_edit_sel != sel_q);

    presc_d = presc_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    snap_d  = snap_q;
    sel_d   = sel_q;

    if (dsp_enable) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;

      if (presc_wrap) begin
        idx_d = (idx_q == LastDigit) ? 3'd0 : idx_q + 3'd1;
      end

      if (frame_wrap) begin
        // Zero-extend every field to a full BCD nibble.
        snap_d = {dsp_s_lsd, {1'b0, dsp_s_msd},
                  dsp_m_lsd, {1'b0, dsp_m_msd},
                  dsp_h_lsd, {2'b00, dsp_h_msd}};
        if (frame_q == FrameLast) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end

      // A new selection restarts the blink visible; overrides any toggle above.
      if (sel_change) begin
        phase_d = 1'b1;
        frame_d = '0;
        sel_d   = dsp_edit_sel;
      end
    end
  end

  // Output decode from the current index and snapshot.
  always_comb begin
    digit = 4'd0;
    field = 2'd0;
    an_d  = 6'h3F;
    seg_d = SegBlank;
    dp_d  = 1'b1;
    blank = 1'b0;

    if (dsp_enable) begin
      case (idx_q)
        3'd0: begin digit = snap_q[0]; field = 2'd1; an_d = 6'b111110; end
        3'd1: begin digit = snap_q[1]; field = 2'd1; an_d = 6'b111101; end
        3'd2: begin digit = snap_q[2]; field = 2'd2; an_d = 6'b111011; end
        3'd3: begin digit = snap_q[3]; field = 2'd2; an_d = 6'b110111; end
        3'd4: begin digit = snap_q[4]; field = 2'd3; an_d = 6'b101111; end
        3'd5: begin digit = snap_q[5]; field = 2'd3; an_d = 6'b011111; end
        default: begin digit = 4'd0; field = 2'd0; an_d = 6'h3F; end
      endcase

      // sel_q of 0 never matches a field, so nothing blanks.
      blank = !phase_q && (sel_q != 2'd0) && (field == sel_q);
      seg_d = blank ? SegBlank : seg_of(digit);
      dp_d  = !((idx_q == 3'd1) || (idx_q == 3'd3));
    end
  end

  always_ff @(posedge dsp_clock or negedge dsp_reset) begin
    if (!dsp_reset) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      frame_q <= '0;
      phase_q <= 1'b1;
      snap_q  <= '0;
      sel_q   <= 2'd0;
      an_q    <= 6'h3F;
      seg_q   <= SegBlank;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign dsp_an  = an_q;
  assign dsp_seg = seg_q;
  assign dsp_dp  = dp_q;

endmodule
